e203_ifu_flush_halt_ctrl: RTL and testbench

IFU-side responder for the two control requests the commit stage issues toward fetch: pipeline flush (`pipe_flush_req`/`pipe_flush_ack` with a two-operand target PC) and WFI halt (`wfi_halt_ifu_req`/`wfi_halt_ifu_ack`). It tracks outstanding instruction-fetch transactions, produces a registered redirect PC for the fetch PC generator, and marks stale responses for discard after a flush. It gates new fetch requests while halting, and acknowledges the halt only once fetch is drained. It sits inside the IFU, between the commit interface and the fetch request/response handshakes.

---
 rtl/e203_ifu_flush_halt_ctrl_pkg.sv | 30 +++
 rtl/e203_ifu_flush_halt_ctrl_if.sv | 56 +++++
 rtl/e203_ifu_ostd_cnt.sv | 60 ++++++
 rtl/e203_ifu_flush_halt_ctrl.sv | 127 ++++++++++++
 tb/tb_e203_ifu_flush_halt_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/e203_ifu_flush_halt_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : e203_ifu_flush_halt_ctrl_pkg                                     |
// | Brief    : Shared PC width, halt-FSM state encodings and flush-target helper|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package e203_ifu_flush_halt_ctrl_pkg;

  localparam int E203_PC_SIZE = 32;

  localparam logic [1:0] E203_IFU_ST_RUN       = 2'd0;
  localparam logic [1:0] E203_IFU_ST_HALT_WAIT = 2'd1;
  localparam logic [1:0] E203_IFU_ST_HALTED    = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN       = E203_IFU_ST_RUN,
    ST_HALT_WAIT = E203_IFU_ST_HALT_WAIT,
    ST_HALTED    = E203_IFU_ST_HALTED
  } halt_st_e;

  // Target wraps modulo 2^E203_PC_SIZE; the carry out is intentionally dropped.
  function automatic logic [E203_PC_SIZE-1:0] flush_target(
    input logic [E203_PC_SIZE-1:0] i_op1,
    input logic [E203_PC_SIZE-1:0] i_op2
  );
    return i_op1 + i_op2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/e203_ifu_flush_halt_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : e203_ifu_flush_halt_ctrl_if                                      |
// | Brief    : Commit/fetch-side signal bundle of the IFU flush/halt responder. |
// |            pipe_flush_pc exists only with E203_FLUSH_PC_BOOST_EN.           |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface e203_ifu_flush_halt_ctrl_if;
  import e203_ifu_flush_halt_ctrl_pkg::*;

  logic                    pipe_flush_req;
  logic                    pipe_flush_ack;
  logic [E203_PC_SIZE-1:0] pipe_flush_add_op1;
  logic [E203_PC_SIZE-1:0] pipe_flush_add_op2;
`ifdef E203_FLUSH_PC_BOOST_EN
  logic [E203_PC_SIZE-1:0] pipe_flush_pc;
`endif
  logic                    wfi_halt_ifu_req;
  logic                    wfi_halt_ifu_ack;
  logic                    ifu_req_hsked;
  logic                    ifu_rsp_hsked;
  logic                    ifu_req_allow;
  logic                    ifu_rsp_drop;
  logic                    redir_vld;
  logic [E203_PC_SIZE-1:0] redir_pc;

`ifdef E203_FLUSH_PC_BOOST_EN
  modport master (
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_pc,
    output wfi_halt_ifu_req, ifu_req_hsked, ifu_rsp_hsked,
    input  pipe_flush_ack, wfi_halt_ifu_ack, ifu_req_allow, ifu_rsp_drop,
    input  redir_vld, redir_pc
  );
  modport slave (
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_pc,
    input  wfi_halt_ifu_req, ifu_req_hsked, ifu_rsp_hsked,
    output pipe_flush_ack, wfi_halt_ifu_ack, ifu_req_allow, ifu_rsp_drop,
    output redir_vld, redir_pc
  );
`else
  modport master (
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
    output wfi_halt_ifu_req, ifu_req_hsked, ifu_rsp_hsked,
    input  pipe_flush_ack, wfi_halt_ifu_ack, ifu_req_allow, ifu_rsp_drop,
    input  redir_vld, redir_pc
  );
  modport slave (
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
    input  wfi_halt_ifu_req, ifu_req_hsked, ifu_rsp_hsked,
    output pipe_flush_ack, wfi_halt_ifu_ack, ifu_req_allow, ifu_rsp_drop,
    output redir_vld, redir_pc
  );
`endif

endinterface
`default_nettype wire

// File: rtl/e203_ifu_ostd_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : e203_ifu_ostd_cnt                                                |
// | Brief    : Saturating up/down counter with load and next-value output.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module e203_ifu_ostd_cnt #(
  parameter  int MAX    = 2,
  parameter  bit CHK_EN = 1'b1,
  localparam int W      = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt
);

  localparam logic [W-1:0] c_max_val = W'(MAX);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_load) begin
      w_nxt = i_load_val;
    end else if (i_inc && !i_dec && (r_cnt != c_max_val)) begin
      w_nxt = r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      w_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_nxt = w_nxt;

  // A net increment at MAX or a net decrement at zero is a handshake protocol error.
  always_ff @(posedge clk) begin
    if (rst_n && CHK_EN && !i_load) begin
      a_no_overflow: assert (!(i_inc && !i_dec && (r_cnt == c_max_val)))
        else $error("e203_ifu_ostd_cnt: increment while at maximum");
      a_no_underflow: assert (!(i_dec && !i_inc && (r_cnt == '0)))
        else $error("e203_ifu_ostd_cnt: decrement while at zero");
    end
  end

endmodule
`default_nettype wire

// File: rtl/e203_ifu_flush_halt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : e203_ifu_flush_halt_ctrl                                         |
// | Brief    : IFU responder for commit flush and WFI halt requests.            |
// |            E203_FLUSH_PC_BOOST_EN: redirect loads pipe_flush_pc directly.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module e203_ifu_flush_halt_ctrl
  import e203_ifu_flush_halt_ctrl_pkg::*;
#(
  parameter int OSTD_MAX = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  e203_ifu_flush_halt_ctrl_if.slave    io_bus
);

  localparam int            CW         = $clog2(OSTD_MAX + 1);
  localparam logic [CW-1:0] c_ostd_max = CW'(OSTD_MAX);

  logic                    w_flush_ack;
  logic [E203_PC_SIZE-1:0] w_flush_tgt;
  logic [CW-1:0]           w_ostd_cnt;
  logic [CW-1:0]           w_ostd_nxt;
  logic [CW-1:0]           w_drop_cnt;
  logic [CW-1:0]           w_drop_nxt_unused;

  logic                    r_redir_vld;
  logic [E203_PC_SIZE-1:0] r_redir_pc;
  halt_st_e                r_state;
  logic                    r_halt_ack;

  assign w_flush_ack = io_bus.pipe_flush_req;

`ifdef E203_FLUSH_PC_BOOST_EN
  logic w_unused_ops;
  assign w_flush_tgt  = io_bus.pipe_flush_pc;
  assign w_unused_ops = ^{io_bus.pipe_flush_add_op1, io_bus.pipe_flush_add_op2};
`else
  assign w_flush_tgt  = flush_target(io_bus.pipe_flush_add_op1, io_bus.pipe_flush_add_op2);
`endif

  e203_ifu_ostd_cnt #(
    .MAX    (OSTD_MAX),
    .CHK_EN (1'b1)
  ) u_ostd_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (io_bus.ifu_req_hsked),
    .i_dec      (io_bus.ifu_rsp_hsked),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_cnt      (w_ostd_cnt),
    .o_nxt      (w_ostd_nxt)
  );

  // Responses arriving while nothing is stale are normal, so no underflow check.
  // The load value excludes any response handshaked in the flush cycle itself.
  e203_ifu_ostd_cnt #(
    .MAX    (OSTD_MAX),
    .CHK_EN (1'b0)
  ) u_drop_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (1'b0),
    .i_dec      (io_bus.ifu_rsp_hsked),
    .i_load     (w_flush_ack),
    .i_load_val (w_ostd_nxt),
    .o_cnt      (w_drop_cnt),
    .o_nxt      (w_drop_nxt_unused)
  );

  // A flush in the same cycle as a fetch handshake keeps the redirect pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else if (w_flush_ack) begin
      r_redir_vld <= 1'b1;
      r_redir_pc  <= w_flush_tgt;
    end else if (io_bus.ifu_req_hsked) begin
      r_redir_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_halt_ack <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (io_bus.wfi_halt_ifu_req) begin
            r_state <= ST_HALT_WAIT;
          end
        end
        ST_HALT_WAIT: begin
          if (!io_bus.wfi_halt_ifu_req) begin
            r_state <= ST_RUN;
          end else if (w_ostd_nxt == '0) begin
            r_state    <= ST_HALTED;
            r_halt_ack <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!io_bus.wfi_halt_ifu_req) begin
            r_state    <= ST_RUN;
            r_halt_ack <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_halt_ack <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.pipe_flush_ack   = w_flush_ack;
  assign io_bus.wfi_halt_ifu_ack = r_halt_ack;
  assign io_bus.ifu_req_allow    = (r_state == ST_RUN) && (w_ostd_cnt < c_ostd_max);
  assign io_bus.ifu_rsp_drop     = (w_drop_cnt != '0);
  assign io_bus.redir_vld        = r_redir_vld;
  assign io_bus.redir_pc         = r_redir_pc;

endmodule
`default_nettype wire

// File: tb/tb_e203_ifu_flush_halt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_e203_ifu_flush_halt_ctrl                                      |
// | Brief    : Directed scoreboard bench for the IFU flush/halt responder.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_e203_ifu_flush_halt_ctrl;
  import e203_ifu_flush_halt_ctrl_pkg::*;

  localparam logic [5:0] M_ACK   = 6'b000001;
  localparam logic [5:0] M_VLD   = 6'b000010;
  localparam logic [5:0] M_PC    = 6'b000100;
  localparam logic [5:0] M_HACK  = 6'b001000;
  localparam logic [5:0] M_DROP  = 6'b010000;
  localparam logic [5:0] M_ALLOW = 6'b100000;
  localparam logic [5:0] M_ALL   = 6'b111111;

  typedef struct {
    int          cyc;
    string       name;
    logic [5:0]  msk;
    logic        ack;
    logic        vld;
    logic [31:0] pc;
    logic        hack;
    logic        drop;
    logic        allow;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t r_e;
  logic r_bad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  e203_ifu_flush_halt_ctrl_if bus();

  e203_ifu_flush_halt_ctrl #(
    .OSTD_MAX (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Expectations are tagged with the cycle they apply to; the monitor checks at negedge.
  task automatic expect_now(input string nm, input logic [5:0] m, input logic a, input logic v,
                            input logic [31:0] pc, input logic h, input logic dr, input logic al);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.msk = m;
    e.ack = a; e.vld = v; e.pc = pc; e.hack = h; e.drop = dr; e.allow = al;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.pipe_flush_req = 1'b0;
    bus.ifu_req_hsked  = 1'b0;
    bus.ifu_rsp_hsked  = 1'b0;
  endtask

  task automatic flush(input logic [31:0] a, input logic [31:0] b);
    bus.pipe_flush_req     = 1'b1;
    bus.pipe_flush_add_op1 = a;
    bus.pipe_flush_add_op2 = b;
`ifdef E203_FLUSH_PC_BOOST_EN
    bus.pipe_flush_pc      = a + b;
`endif
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      r_e   = q.pop_front();
      r_bad = (r_e.cyc != cyc);
      if (r_e.msk[0] && (bus.pipe_flush_ack   !== r_e.ack))   r_bad = 1'b1;
      if (r_e.msk[1] && (bus.redir_vld        !== r_e.vld))   r_bad = 1'b1;
      if (r_e.msk[2] && (bus.redir_pc         !== r_e.pc))    r_bad = 1'b1;
      if (r_e.msk[3] && (bus.wfi_halt_ifu_ack !== r_e.hack))  r_bad = 1'b1;
      if (r_e.msk[4] && (bus.ifu_rsp_drop     !== r_e.drop))  r_bad = 1'b1;
      if (r_e.msk[5] && (bus.ifu_req_allow    !== r_e.allow)) r_bad = 1'b1;
      n_cmp++;
      if (r_bad) begin
        n_bad++;
        $display("FAIL %s cyc=%0d mask=%b got ack=%b vld=%b pc=%h hack=%b drop=%b allow=%b want ack=%b vld=%b pc=%h hack=%b drop=%b allow=%b",
                 r_e.name, cyc, r_e.msk, bus.pipe_flush_ack, bus.redir_vld, bus.redir_pc,
                 bus.wfi_halt_ifu_ack, bus.ifu_rsp_drop, bus.ifu_req_allow,
                 r_e.ack, r_e.vld, r_e.pc, r_e.hack, r_e.drop, r_e.allow);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pipe_flush_req     = 1'b0;
    bus.pipe_flush_add_op1 = '0;
    bus.pipe_flush_add_op2 = '0;
`ifdef E203_FLUSH_PC_BOOST_EN
    bus.pipe_flush_pc      = '0;
`endif
    bus.wfi_halt_ifu_req   = 1'b0;
    bus.ifu_req_hsked      = 1'b0;
    bus.ifu_rsp_hsked      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_now("reset_vals", M_ALL, 0, 0, 32'h0, 0, 0, 1);
    tick();

    // Flush with one outstanding fetch
    bus.ifu_req_hsked = 1'b1;
    expect_now("idle_allow", M_VLD | M_ALLOW, 0, 0, 0, 0, 0, 1);
    tick();
    flush(32'h8000_0000, 32'h10);
    expect_now("flush_ack", M_ACK | M_DROP, 1, 0, 0, 0, 0, 0);
    tick();
    bus.ifu_rsp_hsked = 1'b1;
    expect_now("flush_redir", M_ACK | M_VLD | M_PC | M_DROP, 0, 1, 32'h8000_0010, 0, 1, 0);
    tick();
    bus.ifu_req_hsked = 1'b1;
    expect_now("drop_cleared", M_VLD | M_DROP, 0, 1, 0, 0, 0, 0);
    tick();
    bus.ifu_rsp_hsked = 1'b1;
    expect_now("redir_consumed", M_VLD | M_PC | M_DROP, 0, 0, 32'h8000_0010, 0, 0, 0);
    tick();

    // Wrap-around
    flush(32'hFFFF_FFFC, 32'h8);
    expect_now("wrap_ack", M_ACK, 1, 0, 0, 0, 0, 0);
    tick();
    bus.ifu_req_hsked = 1'b1;
    expect_now("wrap_pc", M_VLD | M_PC, 0, 1, 32'h0000_0004, 0, 0, 0);
    tick();
    bus.ifu_rsp_hsked = 1'b1;
    expect_now("wrap_consumed", M_VLD | M_DROP, 0, 0, 0, 0, 0, 0);
    tick();

    // Halt while draining two fetches, flush while halted, then wake
    bus.ifu_req_hsked = 1'b1;
    tick();
    bus.ifu_req_hsked = 1'b1;
    expect_now("one_ostd_allow", M_ALLOW, 0, 0, 0, 0, 0, 1);
    tick();
    bus.wfi_halt_ifu_req = 1'b1;
    bus.ifu_rsp_hsked    = 1'b1;
    expect_now("full_no_allow", M_ALLOW | M_HACK, 0, 0, 0, 0, 0, 0);
    tick();
    bus.ifu_rsp_hsked = 1'b1;
    expect_now("halt_wait_gate", M_ALLOW | M_HACK, 0, 0, 0, 0, 0, 0);
    tick();
    flush(32'h100, 32'h0);
    expect_now("halted_ack", M_ACK | M_HACK | M_ALLOW, 1, 0, 0, 1, 0, 0);
    tick();
    bus.wfi_halt_ifu_req = 1'b0;
    expect_now("halted_redir", M_VLD | M_PC | M_HACK | M_ALLOW | M_DROP, 0, 1, 32'h100, 1, 0, 0);
    tick();
    bus.ifu_req_hsked = 1'b1;
    expect_now("wake", M_HACK | M_ALLOW | M_VLD, 0, 1, 0, 0, 0, 1);
    tick();
    bus.ifu_rsp_hsked = 1'b1;
    expect_now("wake_consumed", M_VLD | M_HACK, 0, 0, 0, 0, 0, 0);
    tick();

    // Halt request withdrawn while still waiting for a response
    bus.ifu_req_hsked = 1'b1;
    tick();
    bus.wfi_halt_ifu_req = 1'b1;
    expect_now("halt_req_cycle", M_ALLOW | M_HACK, 0, 0, 0, 0, 0, 1);
    tick();
    bus.wfi_halt_ifu_req = 1'b0;
    expect_now("abort_wait", M_ALLOW | M_HACK, 0, 0, 0, 0, 0, 0);
    tick();
    bus.ifu_rsp_hsked = 1'b1;
    expect_now("abort_run", M_ALLOW | M_HACK, 0, 0, 0, 0, 0, 1);
    tick();

    // Simultaneous request, response and flush at one outstanding
    bus.ifu_req_hsked = 1'b1;
    tick();
    bus.ifu_req_hsked = 1'b1;
    bus.ifu_rsp_hsked = 1'b1;
    flush(32'h40, 32'h4);
    expect_now("simul_ack", M_ACK | M_DROP | M_ALLOW, 1, 0, 0, 0, 0, 1);
    tick();
    bus.ifu_rsp_hsked = 1'b1;
    expect_now("simul_redir", M_VLD | M_PC | M_DROP | M_ALLOW, 0, 1, 32'h44, 0, 1, 1);
    tick();
    expect_now("simul_after", M_VLD | M_DROP | M_ALLOW, 0, 1, 0, 0, 0, 1);
    tick();

    // Back-to-back flushes before consumption
    flush(32'hF0, 32'h10);
    tick();
    flush(32'h200, 32'h0);
    expect_now("b2b_first", M_VLD | M_PC, 0, 1, 32'h100, 0, 0, 0);
    tick();
    bus.ifu_req_hsked = 1'b1;
    expect_now("b2b_second", M_VLD | M_PC, 0, 1, 32'h200, 0, 0, 0);
    tick();
    bus.ifu_rsp_hsked = 1'b1;
    expect_now("b2b_consumed", M_VLD | M_PC, 0, 0, 32'h200, 0, 0, 0);
    tick();

    // Asynchronous reset while halted with a redirect pending
    flush(32'h300, 32'h0);
    bus.wfi_halt_ifu_req = 1'b1;
    tick();
    tick();
    expect_now("pre_reset", M_HACK | M_VLD | M_PC | M_ALLOW, 0, 1, 32'h300, 1, 0, 0);
    tick();
    rst_n = 1'b0;
    expect_now("async_reset", M_ALL, 0, 0, 32'h0, 0, 0, 1);
    tick();
    rst_n = 1'b1;
    bus.wfi_halt_ifu_req = 1'b0;
    expect_now("post_reset", M_ALL, 0, 0, 32'h0, 0, 0, 1);
    tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
      n_cmp += q.size();
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
